// File: rtl/exception_controller.sv
// ARMv4 exception prioritiser/sequencer for the LEG pipeline: picks the winning
// writeback-stage exception or interrupt and emits a one-cycle one-hot vector pulse.
module exception_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       StallW,
    input  logic       InstrValidW,
    input  logic       UndefinedInstrW,
    input  logic       SWIW,
    input  logic       PrefetchAbortW,
    input  logic       DataAbortW,
    input  logic       IRQ,
    input  logic       FIQ,
    input  logic       IMaskW,
    input  logic       FMaskW,
    output logic       ExceptionTakenW,
    output logic [6:0] VectorAddressW,
    output logic [4:0] ExceptionModeW,
    output logic       ExceptionSetFW
);

    // state     | meaning
    // RESET_VEC | held in/just out of reset; pipeline flushed, reset vector next
    // IDLE      | evaluating candidates at every unstalled W cycle
    // VEC       | registered vector pulse is on the outputs this cycle
    // WAIT      | re-entry blocked until the handler's first instruction retires
    typedef enum logic [1:0] {
        RESET_VEC = 2'd0,
        IDLE      = 2'd1,
        VEC       = 2'd2,
        WAIT      = 2'd3
    } state_t;

    localparam logic [6:0] VEC_RESET = 7'b0000001;
    localparam logic [6:0] VEC_UNDEF = 7'b0000010;
    localparam logic [6:0] VEC_SWI   = 7'b0000100;
    localparam logic [6:0] VEC_PABT  = 7'b0001000;
    localparam logic [6:0] VEC_DABT  = 7'b0010000;
    localparam logic [6:0] VEC_IRQ   = 7'b0100000;
    localparam logic [6:0] VEC_FIQ   = 7'b1000000;

    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_FIQ = 5'b10001;

    state_t     state, state_d;
    logic       irq_m, irq_s, fiq_m, fiq_s;
    logic       cand_und, cand_swi, cand_pabt, cand_dabt, cand_irq, cand_fiq;
    logic [6:0] sel_vec, vec_d;
    logic [4:0] sel_mode, mode_d;
    logic       sel_setf, setf_d;
    logic       accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_m <= 1'b0;
            irq_s <= 1'b0;
            fiq_m <= 1'b0;
            fiq_s <= 1'b0;
        end else begin
            irq_m <= IRQ;
            irq_s <= irq_m;
            fiq_m <= FIQ;
            fiq_s <= fiq_m;
        end
    end

    // interrupts are only taken at a real instruction boundary
    assign cand_und  = UndefinedInstrW & InstrValidW;
    assign cand_swi  = SWIW & InstrValidW;
    assign cand_pabt = PrefetchAbortW & InstrValidW;
    assign cand_dabt = DataAbortW & InstrValidW;
    assign cand_irq  = irq_s & ~IMaskW & InstrValidW;
    assign cand_fiq  = fiq_s & ~FMaskW & InstrValidW;

    always_comb begin
        sel_vec  = '0;
        sel_mode = '0;
        sel_setf = 1'b0;
        if (cand_dabt) begin
            sel_vec  = VEC_DABT;
            sel_mode = MODE_ABT;
        end else if (cand_fiq) begin
            sel_vec  = VEC_FIQ;
            sel_mode = MODE_FIQ;
            sel_setf = 1'b1;
        end else if (cand_irq) begin
            sel_vec  = VEC_IRQ;
            sel_mode = MODE_IRQ;
        end else if (cand_pabt) begin
            sel_vec  = VEC_PABT;
            sel_mode = MODE_ABT;
        end else if (cand_und) begin
            sel_vec  = VEC_UNDEF;
            sel_mode = MODE_UND;
        end else if (cand_swi) begin
            sel_vec  = VEC_SWI;
            sel_mode = MODE_SVC;
        end
    end

    assign accept = (state == IDLE) & ~StallW & (sel_vec != 7'd0);

    always_comb begin
        state_d = state;
        vec_d   = '0;
        mode_d  = '0;
        setf_d  = 1'b0;
        case (state)
            RESET_VEC: begin
                state_d = WAIT;
                vec_d   = VEC_RESET;
                mode_d  = MODE_SVC;
                setf_d  = 1'b1;
            end
            IDLE: begin
                if (accept) begin
                    state_d = VEC;
                    vec_d   = sel_vec;
                    mode_d  = sel_mode;
                    setf_d  = sel_setf;
                end
            end
            VEC: state_d = WAIT;
            WAIT: begin
                if (InstrValidW & ~StallW)
                    state_d = IDLE;
            end
            default: state_d = RESET_VEC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RESET_VEC;
            VectorAddressW <= '0;
            ExceptionModeW <= '0;
            ExceptionSetFW <= 1'b0;
        end else begin
            state          <= state_d;
            VectorAddressW <= vec_d;
            ExceptionModeW <= mode_d;
            ExceptionSetFW <= setf_d;
        end
    end

    // reset keeps the pipeline flushed even before the state register settles
    assign ExceptionTakenW = reset | (state == RESET_VEC) | accept;

endmodule

// File: tb/tb_exception_controller.sv
// Randomised + directed bench for exception_controller against a behavioural model.
module tb_exception_controller;

    logic       clk = 1'b0;
    logic       reset, StallW, InstrValidW, UndefinedInstrW, SWIW, PrefetchAbortW, DataAbortW;
    logic       IRQ, FIQ, IMaskW, FMaskW;
    logic       ExceptionTakenW;
    logic [6:0] VectorAddressW;
    logic [4:0] ExceptionModeW;
    logic       ExceptionSetFW;

    int n_checks = 0;
    int n_fail   = 0;

    exception_controller dut (
        .clk(clk), .reset(reset), .StallW(StallW), .InstrValidW(InstrValidW),
        .UndefinedInstrW(UndefinedInstrW), .SWIW(SWIW), .PrefetchAbortW(PrefetchAbortW),
        .DataAbortW(DataAbortW), .IRQ(IRQ), .FIQ(FIQ), .IMaskW(IMaskW), .FMaskW(FMaskW),
        .ExceptionTakenW(ExceptionTakenW), .VectorAddressW(VectorAddressW),
        .ExceptionModeW(ExceptionModeW), .ExceptionSetFW(ExceptionSetFW)
    );

    always #5 clk = ~clk;

    // behavioural model: pin history, sequencing flags, expected registered outputs
    bit         m_known = 0;
    bit         m_rv = 0, m_pulse = 0, m_blocked = 0;
    bit         irq_hist[2], fiq_hist[2];
    logic [6:0] e_vec = '0;
    logic [4:0] e_mode = '0;
    logic       e_setf = 1'b0;
    logic [4:0] mode_of[7] = '{5'b10011, 5'b11011, 5'b10011, 5'b10111, 5'b10111, 5'b10010, 5'b10001};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // winning vector bit index by architectural priority, -1 when nothing pending
    function automatic int winner();
        if (!InstrValidW)              return -1;
        if (DataAbortW)                return 4;
        if (fiq_hist[1] && !FMaskW)    return 6;
        if (irq_hist[1] && !IMaskW)    return 5;
        if (PrefetchAbortW)            return 3;
        if (UndefinedInstrW)           return 1;
        if (SWIW)                      return 2;
        return -1;
    endfunction

    function automatic bit can_take();
        return !m_rv && !m_pulse && !m_blocked && !StallW && (winner() >= 0);
    endfunction

    task automatic model_update();
        int w;
        w = winner();
        if (reset) begin
            m_known = 1; m_rv = 1; m_pulse = 0; m_blocked = 0;
            irq_hist = '{0, 0}; fiq_hist = '{0, 0};
            e_vec = '0; e_mode = '0; e_setf = 1'b0;
            return;
        end
        e_vec = '0; e_mode = '0; e_setf = 1'b0;
        if (m_rv) begin
            e_vec = 7'd1; e_mode = mode_of[0]; e_setf = 1'b1;
            m_rv = 0; m_blocked = 1;
        end else if (m_pulse) begin
            m_pulse = 0; m_blocked = 1;
        end else if (m_blocked) begin
            if (InstrValidW && !StallW) m_blocked = 0;
        end else if (can_take()) begin
            e_vec = 7'd1 << w; e_mode = mode_of[w]; e_setf = (w == 6);
            m_pulse = 1;
        end
        irq_hist[1] = irq_hist[0]; irq_hist[0] = IRQ;
        fiq_hist[1] = fiq_hist[0]; fiq_hist[0] = FIQ;
    endtask

    task automatic step();
        #1;
        if (m_known) begin
            chk("taken", {31'd0, ExceptionTakenW}, {31'd0, reset || m_rv || can_take()});
            chk("vector", {25'd0, VectorAddressW}, {25'd0, e_vec});
            chk("mode", {27'd0, ExceptionModeW}, {27'd0, e_mode});
            chk("setf", {31'd0, ExceptionSetFW}, {31'd0, e_setf});
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic quiet();
        StallW = 0; InstrValidW = 0; UndefinedInstrW = 0; SWIW = 0;
        PrefetchAbortW = 0; DataAbortW = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // one retiring bubble-free instruction so WAIT releases
    task automatic retire();
        quiet(); InstrValidW = 1; step(); quiet();
    endtask

    initial begin
        reset = 1; quiet(); IRQ = 0; FIQ = 0; IMaskW = 1; FMaskW = 1;
        run(3);
        reset = 0;
        run(4);
        retire();
        run(2);

        // undef + swi together: undef wins
        InstrValidW = 1; UndefinedInstrW = 1; SWIW = 1; step(); quiet();
        run(2); retire(); run(1);

        // data abort with fiq pending: abort first, fiq after handler retires
        FIQ = 1; FMaskW = 0; run(3);
        InstrValidW = 1; DataAbortW = 1; step(); quiet();
        run(2); retire();
        InstrValidW = 1; step(); quiet();
        run(2); FIQ = 0; retire(); FMaskW = 1; run(3);

        // masked irq stays invisible, unmasking takes it at a valid W
        IRQ = 1; IMaskW = 1;
        for (int i = 0; i < 20; i++) begin InstrValidW = 1; step(); end
        IMaskW = 0; InstrValidW = 1; step(); quiet();
        IRQ = 0; run(2); IMaskW = 1; retire(); run(3);

        // stalled prefetch abort is held off until the stall drops
        InstrValidW = 1; PrefetchAbortW = 1; StallW = 1; run(4);
        StallW = 0; step(); quiet();
        run(2); retire(); run(1);

        // reset arriving while the swi pulse is out
        InstrValidW = 1; SWIW = 1; step(); quiet();
        reset = 1; run(2);
        reset = 0; run(4); retire(); run(1);

        // randomised traffic
        for (int i = 0; i < 4000; i++) begin
            reset           = ($urandom_range(199, 0) == 0);
            StallW          = ($urandom_range(99, 0) < 25);
            InstrValidW     = ($urandom_range(99, 0) < 70);
            UndefinedInstrW = ($urandom_range(99, 0) < 8);
            SWIW            = ($urandom_range(99, 0) < 8);
            PrefetchAbortW  = ($urandom_range(99, 0) < 6);
            DataAbortW      = ($urandom_range(99, 0) < 5);
            if ($urandom_range(99, 0) < 5)  IRQ = ~IRQ;
            if ($urandom_range(99, 0) < 5)  FIQ = ~FIQ;
            if ($urandom_range(99, 0) < 10) IMaskW = ~IMaskW;
            if ($urandom_range(99, 0) < 10) FMaskW = ~FMaskW;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
